// File: rtl/bloom_agg_pkg.sv
// Shared types and widths for the bloom match aggregator.
// Result summaries travel through pending slots and the FIFO as res_t.
package bloom_agg_pkg;

  localparam int CH_CNT_D = 4;
  localparam int MIN_S_D  = 4;
  localparam int MAX_S_D  = 16;
  localparam int OFS_W_D  = 16;
  localparam int LEN_CNT  = MAX_S_D - MIN_S_D + 1;
  localparam int CH_W     = (CH_CNT_D > 1) ? $clog2(CH_CNT_D) : 1;
  localparam int DROP_W   = 16;
  localparam int STAT_W   = 32;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic               match;
    logic [LEN_CNT-1:0] len_map;
    logic [OFS_W_D-1:0] ofs;
  } res_t;

endpackage

// File: rtl/bloom_match_agg_if.sv
// Result handshake bundle of the aggregator.
// master drives the summary, slave supplies ready.
interface bloom_match_agg_if #(
  parameter int CH_W    = bloom_agg_pkg::CH_W,
  parameter int LEN_CNT = bloom_agg_pkg::LEN_CNT,
  parameter int OFS_W   = bloom_agg_pkg::OFS_W_D
);

  logic               res_val_o;
  logic               res_rdy_i;
  logic [CH_W-1:0]    res_ch_o;
  logic               res_match_o;
  logic [LEN_CNT-1:0] res_len_map_o;
  logic [OFS_W-1:0]   res_ofs_o;

  modport master (
    output res_val_o,
    output res_ch_o,
    output res_match_o,
    output res_len_map_o,
    output res_ofs_o,
    input  res_rdy_i
  );

  modport slave (
    input  res_val_o,
    input  res_ch_o,
    input  res_match_o,
    input  res_len_map_o,
    input  res_ofs_o,
    output res_rdy_i
  );

endinterface

// File: rtl/bloom_res_fifo.sv
// Show-ahead result FIFO; head is zero while empty.
// A push into a full FIFO is taken when a pop happens the same cycle.
module bloom_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign full_o  = (cnt == (AW+1)'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/bloom_match_agg.sv
// Per-channel bloom match aggregation into packet summaries.
// Optional statistics counters: define BLOOM_AGG_STATS_EN.
module bloom_match_agg
  import bloom_agg_pkg::*;
#(
  parameter int CH_CNT    = CH_CNT_D,
  parameter int MIN_S     = MIN_S_D,
  parameter int MAX_S     = MAX_S_D,
  parameter int PIPE_LAT  = 2,
  parameter int OFS_W     = OFS_W_D,
  parameter int RES_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CH_CNT-1:0]      val_i,
  input  logic [CH_CNT-1:0]      eop_i,
  input  logic [CH_CNT-1:0][MAX_S-MIN_S:0] match_i,
  input  logic [CH_CNT-1:0]      clr_i,
  bloom_match_agg_if.master      res,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic [STAT_W-1:0]      pkt_cnt_o,
  output logic [STAT_W-1:0]      hit_cnt_o
);

  localparam int LN = MAX_S - MIN_S + 1;
  localparam int CW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
  localparam int RW = $bits(res_t);

  logic [CH_CNT-1:0] val_d [PIPE_LAT];
  logic [CH_CNT-1:0] eop_d [PIPE_LAT];
  logic [CH_CNT-1:0] dval;
  logic [CH_CNT-1:0] deop;
  logic [CH_CNT-1:0] fin;

  logic [OFS_W-1:0]  cnt_q [CH_CNT];
  logic [LN-1:0]     map_q [CH_CNT];
  logic [OFS_W-1:0]  ofs_q [CH_CNT];
  logic [CH_CNT-1:0] hit_q;
  logic [LN-1:0]     mcur  [CH_CNT];
  logic [LN-1:0]     mnxt  [CH_CNT];
  res_t              sum   [CH_CNT];

  logic [CH_CNT-1:0] pend_v;
  res_t              pend_d [CH_CNT];
  logic [CH_CNT-1:0] gnt;
  logic [CH_CNT-1:0] load;
  logic [CH_CNT-1:0] drop;
  logic [CW-1:0]     rr_q;
  logic [CW-1:0]     gnt_idx;
  logic              found;
  int                idx;

  logic [DROP_W:0]   ndrop;
  logic [DROP_W:0]   drop_sum;

  logic [RW-1:0]     fifo_q;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              can_push;
  res_t              head;

  // align rx valid/eop with the bloommem match latency
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        val_d[i] <= '0;
        eop_d[i] <= '0;
      end
    end else begin
      val_d[0] <= val_i;
      eop_d[0] <= eop_i;
      for (int i = 1; i < PIPE_LAT; i++) begin
        val_d[i] <= val_d[i-1];
        eop_d[i] <= eop_d[i-1];
      end
    end
  end

  assign dval = val_d[PIPE_LAT-1];
  assign deop = eop_d[PIPE_LAT-1];

  // summary as it would close this cycle, current matches included
  always_comb begin
    for (int c = 0; c < CH_CNT; c++) begin
      fin[c]         = dval[c] && deop[c];
      mcur[c]        = dval[c] ? match_i[c] : '0;
      mnxt[c]        = map_q[c] | mcur[c];
      sum[c].ch      = CW'(c);
      sum[c].match   = |mnxt[c];
      sum[c].len_map = mnxt[c];
      if (hit_q[c])
        sum[c].ofs = ofs_q[c];
      else if (|mcur[c])
        sum[c].ofs = cnt_q[c];
      else
        sum[c].ofs = '0;
    end
  end

  // byte counter and match accumulators per channel
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH_CNT; c++) begin
        cnt_q[c] <= '0;
        map_q[c] <= '0;
        ofs_q[c] <= '0;
      end
      hit_q <= '0;
    end else begin
      for (int c = 0; c < CH_CNT; c++) begin
        if (fin[c]) begin
          cnt_q[c] <= '0;
          map_q[c] <= '0;
          ofs_q[c] <= '0;
          hit_q[c] <= 1'b0;
        end else begin
          if (dval[c] && cnt_q[c] != '1)
            cnt_q[c] <= cnt_q[c] + 1'b1;
          if (clr_i[c]) begin
            map_q[c] <= '0;
            ofs_q[c] <= '0;
            hit_q[c] <= 1'b0;
          end else if (|mcur[c]) begin
            map_q[c] <= mnxt[c];
            if (!hit_q[c]) begin
              hit_q[c] <= 1'b1;
              ofs_q[c] <= cnt_q[c];
            end
          end
        end
      end
    end
  end

  assign pop      = res.res_val_o && res.res_rdy_i;
  assign can_push = !full || pop;
  assign push     = |gnt;

  // round-robin pick of one pending slot for the FIFO
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < CH_CNT; k++) begin
      idx = (int'(rr_q) + k) % CH_CNT;
      if (!found && pend_v[idx]) begin
        found   = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
    if (found && can_push) gnt[gnt_idx] = 1'b1;
  end

  // a slot being granted this cycle can take the next summary
  always_comb begin
    ndrop = '0;
    for (int c = 0; c < CH_CNT; c++) begin
      load[c] = fin[c] && (!pend_v[c] || gnt[c]);
      drop[c] = fin[c] && pend_v[c] && !gnt[c];
      ndrop   = ndrop + (DROP_W+1)'(drop[c]);
    end
    drop_sum = {1'b0, drop_cnt_o} + ndrop;
  end

  // pending slots, arbiter pointer and drop statistics
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_v     <= '0;
      rr_q       <= '0;
      drop_cnt_o <= '0;
      for (int c = 0; c < CH_CNT; c++) pend_d[c] <= '0;
    end else begin
      for (int c = 0; c < CH_CNT; c++) begin
        if (load[c]) begin
          pend_v[c] <= 1'b1;
          pend_d[c] <= sum[c];
        end else if (gnt[c]) begin
          pend_v[c] <= 1'b0;
        end
      end
      if (push)
        rr_q <= (gnt_idx == CW'(CH_CNT-1)) ? '0 : gnt_idx + 1'b1;
      drop_cnt_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  bloom_res_fifo #(
    .W     (RW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (pend_d[gnt_idx]),
    .pop_i   (pop),
    .data_o  (fifo_q),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head              = fifo_q;
  assign res.res_val_o     = !empty;
  assign res.res_ch_o      = head.ch;
  assign res.res_match_o   = head.match;
  assign res.res_len_map_o = head.len_map;
  assign res.res_ofs_o     = head.ofs;

`ifdef BLOOM_AGG_STATS_EN
  // popped summaries and popped hits, both wrapping
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_o <= '0;
      hit_cnt_o <= '0;
    end else if (pop) begin
      pkt_cnt_o <= pkt_cnt_o + 1'b1;
      if (head.match) hit_cnt_o <= hit_cnt_o + 1'b1;
    end
  end
`else
  assign pkt_cnt_o = '0;
  assign hit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bloom_match_agg.sv
// Directed bench for bloom_match_agg with a result scoreboard.
// Stats expectations follow BLOOM_AGG_STATS_EN.
module tb_bloom_match_agg;
  import bloom_agg_pkg::*;

  localparam int CH = 4;
  localparam int LN = LEN_CNT;
  localparam int PL = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [CH-1:0]         val = '0;
  logic [CH-1:0]         eop = '0;
  logic [CH-1:0]         clr = '0;
  logic [CH-1:0][LN-1:0] match = '0;
  logic [15:0]           drop_cnt;
  logic [31:0]           pkt_cnt;
  logic [31:0]           hit_cnt;

  bloom_match_agg_if #(
    .CH_W(CH_W), .LEN_CNT(LN), .OFS_W(OFS_W_D)
  ) bus ();

  bloom_match_agg dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .val_i      (val),
    .eop_i      (eop),
    .match_i    (match),
    .clr_i      (clr),
    .res        (bus),
    .drop_cnt_o (drop_cnt),
    .pkt_cnt_o  (pkt_cnt),
    .hit_cnt_o  (hit_cnt)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one packet per selected channel, matches/clr aligned to delayed stream
  task automatic send(input logic [CH-1:0] chs, input int n,
                      input int mb, input int ml, input int cb,
                      input bit keep);
    res_t e;
    bit   hit;
    hit = (mb >= 0) && !(cb >= 0 && cb < n - 1 && mb <= cb);
    for (int c = 0; c < n + PL; c++) begin
      val   = (c < n) ? chs : '0;
      eop   = (c == n - 1) ? chs : '0;
      match = '0;
      clr   = '0;
      for (int k = 0; k < CH; k++) begin
        if (chs[k]) begin
          if (mb >= 0 && c - PL == mb) match[k][ml] = 1'b1;
          if (cb >= 0 && c - PL == cb) clr[k] = 1'b1;
        end
      end
      if (keep && c == n - 1 + PL) begin
        for (int k = 0; k < CH; k++) begin
          if (chs[k]) begin
            e.ch      = CH_W'(k);
            e.match   = hit;
            e.len_map = '0;
            if (hit) e.len_map[ml] = 1'b1;
            e.ofs     = hit ? OFS_W_D'(mb) : '0;
            exp_q.push_back(e);
          end
        end
      end
      tick();
    end
    val   = '0;
    eop   = '0;
    match = '0;
    clr   = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_empty"}, 64'(bus.res_val_o), 64'd0);
  endtask

  // scoreboard: compare every popped result against the queue head
  always @(negedge clk) begin
    res_t e;
    if (rst_n && bus.res_val_o && bus.res_rdy_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("res_ch", 64'(bus.res_ch_o), 64'(e.ch));
        check("res_match", 64'(bus.res_match_o), 64'(e.match));
        check("res_len_map", 64'(bus.res_len_map_o), 64'(e.len_map));
        check("res_ofs", 64'(bus.res_ofs_o), 64'(e.ofs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.res_rdy_i = 1'b0;
    tick();
    tick();
    check("rst_val", 64'(bus.res_val_o), 64'd0);
    check("rst_ch", 64'(bus.res_ch_o), 64'd0);
    check("rst_match", 64'(bus.res_match_o), 64'd0);
    check("rst_len", 64'(bus.res_len_map_o), 64'd0);
    check("rst_ofs", 64'(bus.res_ofs_o), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_pkt", 64'(pkt_cnt), 64'd0);
    check("rst_hit", 64'(hit_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // all channels close in the same cycle
    bus.res_rdy_i = 1'b1;
    send(4'hF, 6, 2, 3, -1, 1'b1);
    tick();
    for (int i = 0; i < CH; i++) begin
      check("rr_val", 64'(bus.res_val_o), 64'd1);
      check("rr_order", 64'(bus.res_ch_o), 64'(i));
      tick();
    end
    check("rr_drop", 64'(drop_cnt), 64'd0);
    drain("drain_rr");

    // single packet latency and offset
    send(4'b0001, 10, 7, 1, -1, 1'b1);
    check("lat_t1", 64'(bus.res_val_o), 64'd0);
    tick();
    check("lat_t2", 64'(bus.res_val_o), 64'd1);
    check("lat_ofs", 64'(bus.res_ofs_o), 64'd7);
    check("lat_len", 64'(bus.res_len_map_o), 64'h2);
    drain("drain_lat");

    // clear mid-packet vs clear on the eop cycle
    send(4'b0100, 8, 3, 0, 5, 1'b1);
    send(4'b0100, 8, 3, 4, 7, 1'b1);
    drain("drain_clr");

    // backpressure: four in FIFO, one pending, one dropped
    bus.res_rdy_i = 1'b0;
    for (int p = 0; p < 6; p++)
      send(4'b0010, 4, (p % 3) + 1, p, -1, p != 5);
    check("bp_drop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_val", 64'(bus.res_val_o), 64'd1);
      check("bp_ch", 64'(bus.res_ch_o), 64'd1);
      check("bp_ofs", 64'(bus.res_ofs_o), 64'd1);
      check("bp_len", 64'(bus.res_len_map_o), 64'h1);
      tick();
    end
    bus.res_rdy_i = 1'b1;
    drain("drain_bp");
    check("bp_drop_after", 64'(drop_cnt), 64'd1);

    // reset with a result queued and a packet in flight
    bus.res_rdy_i = 1'b0;
    send(4'b1000, 5, 2, 2, -1, 1'b1);
    tick();
    check("pre_rst_val", 64'(bus.res_val_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      val   = 4'b0001;
      match = '0;
      if (c == PL) match[0][0] = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    val   = '0;
    match = '0;
    #1;
    check("mid_rst_val", 64'(bus.res_val_o), 64'd0);
    check("mid_rst_ch", 64'(bus.res_ch_o), 64'd0);
    check("mid_rst_match", 64'(bus.res_match_o), 64'd0);
    check("mid_rst_ofs", 64'(bus.res_ofs_o), 64'd0);
    check("mid_rst_len", 64'(bus.res_len_map_o), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // five packets after reset, two of them hits
    bus.res_rdy_i = 1'b1;
    send(4'b0001, 6, -1, 0, -1, 1'b1);
    send(4'b0010, 7, 4, 6, -1, 1'b1);
    send(4'b0100, 3, -1, 0, -1, 1'b1);
    send(4'b1000, 5, 0, 12, -1, 1'b1);
    send(4'b0001, 4, -1, 0, -1, 1'b1);
    drain("drain_stats");
`ifdef BLOOM_AGG_STATS_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'd5);
    check("hit_cnt", 64'(hit_cnt), 64'd2);
`else
    check("pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("hit_cnt", 64'(hit_cnt), 64'd0);
`endif
    check("final_drop", 64'(drop_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/bloom_match_agg.md
BLOOM_MATCH_AGG -- requirements
Module: bloom_match_agg

Interface
REQ-001 SHALL have parameters: CH_CNT, default 4, number of search channels; MIN_S, default 4, shortest pattern length; MAX_S, default 16, longest pattern length; PIPE_LAT, default 2, cycles from rx eop/val to match alignment; OFS_W, default 16, byte-offset width; RES_DEPTH, default 4, result FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports: clk_i  in  1  single clock; rst_n_i  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: val_i  in  CH_CNT  per-channel rx byte valid; eop_i  in  CH_CNT  per-channel rx end of packet.
REQ-004 SHALL have ports: match_i  in  CH_CNT x (MAX_S-MIN_S+1)  per-channel, per-length bloommem match; clr_i  in  CH_CNT  per-channel full-clear strobe.
REQ-005 SHALL have ports: res_val_o  out  1; res_rdy_i  in  1; res_ch_o  out  $clog2(CH_CNT); res_match_o  out  1; res_len_map_o  out  MAX_S-MIN_S+1; res_ofs_o  out  OFS_W  first-match byte offset.
REQ-006 SHALL have ports: drop_cnt_o  out  16  summaries lost; pkt_cnt_o, hit_cnt_o  out  32 each  statistics.

Function
REQ-007 SHALL delay val_i/eop_i per channel by PIPE_LAT registers (dval, deop); match_i is used undelayed.
REQ-008 SHALL count dval bytes per channel in an OFS_W counter, saturating at all-ones, reset to 0 after each deop&&dval.
REQ-009 SHALL OR-accumulate match_i into a per-channel len_map and latch the byte counter as ofs on the first match of a packet.
REQ-010 SHALL include matches present in the deop&&dval cycle in that packet's summary.
REQ-011 SHALL, on deop&&dval, load the summary {ch, |len_map, len_map, ofs} into the channel's one-entry pending slot next cycle and clear the accumulators.
REQ-012 SHALL, on clr_i without deop, clear that channel's len_map and ofs-latched flag; clr_i with deop: summary uses pre-clear state, accumulators cleared.
REQ-013 SHALL, when deop&&dval arrives while the pending slot is still occupied, discard the new summary and increment drop_cnt_o (saturating at 0xFFFF).
REQ-014 SHALL move one pending slot per cycle into the result FIFO via round-robin arbitration (pointer advances past granted channel), only when FIFO is not full.
REQ-015 SHALL present FIFO head on res_* with res_val_o high while non-empty; pop on res_val_o&&res_rdy_i; res_* stable while res_val_o&&!res_rdy_i.
REQ-016 SHALL permit push and pop in the same cycle when full (net occupancy unchanged).
REQ-017 SHALL give latency: deop in cycle t, empty FIFO, no contention -> res_val_o high in cycle t+2.
REQ-018 SHALL report res_ofs_o = 0 and res_len_map_o = 0 when res_match_o = 0.

Reset
REQ-019 SHALL, on rst_n_i low, asynchronously clear delay lines, counters, accumulators, pending slots, FIFO pointers, arbiter pointer (channel 0), drop_cnt_o, pkt_cnt_o, hit_cnt_o; res_val_o = 0 and all res_* = 0.
REQ-020 SHALL discard any partial packet in flight at reset; the first summary after reset covers only bytes after deassertion.

Configuration
REQ-021 SHALL, with BLOOM_AGG_STATS_EN defined, increment pkt_cnt_o on each FIFO pop and hit_cnt_o on each pop with res_match_o=1 (both wrap); without it, both outputs tied to 0 and no counter logic exists.

Structure
REQ-022 SHALL place the result-summary struct typedef, LEN_CNT = MAX_S-MIN_S+1 and counter widths in package bloom_agg_pkg.
REQ-023 SHALL implement the result FIFO as sub-module bloom_res_fifo (parametrised width/depth, full/empty, show-ahead).

Verification
REQ-024 SHALL cover: ch0 10-byte packet, match_i[ch0][len 5] high at byte 7 -> one result ch=0, match=1, len_map bit(5-MIN_S)=1, ofs=7, at t+2.
REQ-025 SHALL cover: all 4 channels deop in same cycle, res_rdy_i=1 -> results in order ch0,1,2,3 on consecutive cycles, drop_cnt_o=0.
REQ-026 SHALL cover: res_rdy_i=0, 6 packets on ch1 -> 4 in FIFO, 1 pending, 1 dropped, drop_cnt_o=1, res_* stable.
REQ-027 SHALL cover: match at byte 3, clr_i at byte 5, eop at byte 8 -> result match=0; clr_i on eop cycle -> match=1.
REQ-028 SHALL cover: rst_n_i low mid-packet for 1 cycle -> outputs 0 immediately; next full packet without match -> match=0, ofs=0.
REQ-029 SHALL cover: BLOOM_AGG_STATS_EN defined, 5 packets with 2 matches popped -> pkt_cnt_o=5, hit_cnt_o=2; undefined -> both 0.
